// File: rtl/cgol_pkg.sv
// rtl/cgol_pkg.sv - shared types, window slot constants, default rule masks and wrap helpers
package cgol_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EVAL,
        WRITE,
        DONE
    } state_t;

    // Window slots are numbered row-major over (dr,dc) in {-1,0,+1}^2
    localparam logic [3:0] SLOT_FIRST     = 4'd0;
    localparam logic [3:0] SLOT_TOP_RIGHT = 4'd2;
    localparam logic [3:0] SLOT_CENTRE    = 4'd4;
    localparam logic [3:0] SLOT_LAST      = 4'd8;

    // Conway's B3/S23
    localparam logic [8:0] MASK_B3  = 9'b000001000;
    localparam logic [8:0] MASK_S23 = 9'b000001100;

    // Toroidal increment by compare/select: limit-1 wraps to 0
    function automatic logic [31:0] wrap_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value == limit - 32'd1) ? 32'd0 : value + 32'd1;
    endfunction

    // Toroidal decrement by compare/select: 0 wraps to limit-1
    function automatic logic [31:0] wrap_dec(input logic [31:0] value, input logic [31:0] limit);
        return (value == 32'd0) ? limit - 32'd1 : value - 32'd1;
    endfunction

endpackage

// File: rtl/cgol_rule.sv
// rtl/cgol_rule.sv - combinational birth/survive rule over a 3x3 window
module cgol_rule
    import cgol_pkg::*;
#(
    parameter logic [8:0] BIRTH_MASK   = MASK_B3,
    parameter logic [8:0] SURVIVE_MASK = MASK_S23
) (
    input  logic [8:0] window,
    output logic       next_state,
    output logic [3:0] count
);

    // Count the eight neighbours, then look the result up in the mask for the centre's state
    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (i != int'(SLOT_CENTRE)) begin
                count = count + 4'(window[i]);
            end
        end
        next_state = window[SLOT_CENTRE] ? SURVIVE_MASK[count] : BIRTH_MASK[count];
    end

endmodule

// File: rtl/cgol_engine.sv
// rtl/cgol_engine.sv - Game of Life generation engine; CGOL_WINDOW_REUSE_EN enables column window reuse
module cgol_engine
    import cgol_pkg::*;
#(
    parameter int          ROWS         = 8,
    parameter int          COLS         = 8,
    parameter logic [8:0]  BIRTH_MASK   = MASK_B3,
    parameter logic [8:0]  SURVIVE_MASK = MASK_S23,
    parameter int          GEN_W        = 16,
    parameter int          ADDR_W       = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_valid,
    input  logic              i_rd_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_wr_data,
    input  logic              i_wr_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [GEN_W-1:0]  o_gen_count,
    output logic [ADDR_W:0]   o_live_count
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
`ifdef CGOL_WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    state_t          state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [3:0]      slot;
    logic [8:0]      window;
    logic [ADDR_W:0] acc;

    logic            col_last;
    logic            row_last;
    logic [CW-1:0]   col_nxt;
    logic [RW-1:0]   row_nxt;
    logic [3:0]      slot_step;
    logic [3:0]      cell_slot;
    logic [ADDR_W-1:0] addr_same_cell;
    logic [ADDR_W-1:0] addr_next_cell;
    logic [ADDR_W-1:0] addr_cell;
    logic            next_bit;
    logic [3:0]      nbr_count_unused;

    // Board address of a window slot around cell (r,c), wrapping at the board edges
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                                    input logic [3:0] s);
        logic [RW-1:0] rr;
        logic [CW-1:0] cc;
        if (s < 4'd3)      rr = RW'(wrap_dec(32'(r), ROWS));
        else if (s < 4'd6) rr = r;
        else               rr = RW'(wrap_inc(32'(r), ROWS));
        case (s)
            4'd0, 4'd3, 4'd6: cc = CW'(wrap_dec(32'(c), COLS));
            4'd2, 4'd5, 4'd8: cc = CW'(wrap_inc(32'(c), COLS));
            default:          cc = c;
        endcase
        return ADDR_W'(32'(rr) * COLS + 32'(cc));
    endfunction

    // Next-cell position and the read addresses the FSM may issue next
    always_comb begin
        col_last       = (32'(col) == COLS - 1);
        row_last       = (32'(row) == ROWS - 1);
        col_nxt        = CW'(wrap_inc(32'(col), COLS));
        row_nxt        = col_last ? RW'(wrap_inc(32'(row), ROWS)) : row;
        // With reuse, cells past the first in a row only refill the right column
        slot_step      = (REUSE && col != '0) ? 4'd3 : 4'd1;
        cell_slot      = (REUSE && !col_last) ? SLOT_TOP_RIGHT : SLOT_FIRST;
        addr_same_cell = slot_addr(row, col, slot + slot_step);
        addr_next_cell = slot_addr(row_nxt, col_nxt, cell_slot);
        addr_cell      = ADDR_W'(32'(row) * COLS + 32'(col));
    end

    cgol_rule #(
        .BIRTH_MASK   (BIRTH_MASK),
        .SURVIVE_MASK (SURVIVE_MASK)
    ) u_rule (
        .window     (window),
        .next_state (next_bit),
        .count      (nbr_count_unused)
    );

    // Generation sequencer: fetch window, evaluate, write, advance; outputs registered on transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            slot         <= '0;
            window       <= '0;
            acc          <= '0;
            o_rd_en      <= 1'b0;
            o_rd_addr    <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_gen_count  <= '0;
            o_live_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        row       <= '0;
                        col       <= '0;
                        slot      <= SLOT_FIRST;
                        o_busy    <= 1'b1;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= slot_addr('0, '0, SLOT_FIRST);
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    o_rd_en <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (i_rd_valid) begin
                        window[slot] <= i_rd_data;
                        if (slot == SLOT_LAST) begin
                            state <= EVAL;
                        end else begin
                            slot      <= slot + slot_step;
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= addr_same_cell;
                            state     <= FETCH;
                        end
                    end
                end
                EVAL: begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= addr_cell;
                    o_wr_data <= next_bit;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (i_wr_ready) begin
                        o_wr_en <= 1'b0;
                        acc     <= acc + (ADDR_W + 1)'(o_wr_data);
                        if (col_last && row_last) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            col       <= col_nxt;
                            row       <= row_nxt;
                            slot      <= cell_slot;
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= addr_next_cell;
                            state     <= FETCH;
                            // Shift the two known columns left; the right column is refetched
                            if (REUSE && !col_last) begin
                                window <= {window[8], window[8], window[7], window[5], window[5],
                                           window[4], window[2], window[2], window[1]};
                            end
                        end
                    end
                end
                DONE: begin
                    o_done       <= 1'b0;
                    o_gen_count  <= o_gen_count + GEN_W'(1);
                    o_live_count <= acc;
                    acc          <= '0;
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cgol_engine.md
Name: cgol_engine

Overview:
Parametrised Game of Life generation engine for a ROWS x COLS toroidal board held by the memory controller. On i_start it walks every cell in row-major order and fetches the 3x3 neighbourhood through a read handshake. It evaluates a configurable birth/survive rule and writes the result to the controller's next-generation buffer through a write handshake. It then pulses o_done to the top state machine. Live-cell population and generation count are reported for display and debug.

Parameters:
ROWS, 8, board rows (>=3, any integer, not restricted to powers of two)
COLS, 8, board columns (>=3, any integer)
BIRTH_MASK, 9'b000001000, bit n set: a dead cell with n live neighbours is born (default B3)
SURVIVE_MASK, 9'b000001100, bit n set: a live cell with n live neighbours survives (default S23)
GEN_W, 16, generation counter width
ADDR_W, $clog2(ROWS*COLS), derived address width; not to be overridden

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle start pulse from top FSM
o_rd_en  out  1  read request valid
o_rd_addr  out  ADDR_W  read address = row*COLS+col
i_rd_valid  in  1  read data valid
i_rd_data  in  1  cell value
o_wr_en  out  1  write request valid
o_wr_addr  out  ADDR_W  write address
o_wr_data  out  1  next-state cell value
i_wr_ready  in  1  controller accepts write
o_busy  out  1  generation in progress
o_done  out  1  one-cycle pulse, generation complete
o_gen_count  out  GEN_W  completed generations, wraps
o_live_count  out  ADDR_W+1  live cells written in last completed generation

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Internal row/col/window/population registers 0.
- States: IDLE -> FETCH -> WAIT -> (FETCH | EVAL) -> WRITE -> (FETCH | DONE) -> IDLE.
- IDLE: i_start=1 loads row=col=0, sets o_busy, enters FETCH. i_start is ignored in every other state.
- FETCH: o_rd_en=1 for exactly one cycle with the address of the next window cell; goes to WAIT. Only one read is outstanding at a time.
- WAIT: holds until i_rd_valid. Read latency is arbitrary, >=1 cycle. On valid, captures i_rd_data into the window slot.
  - If window slots remain, returns to FETCH; otherwise goes to EVAL.
- Window order: offsets (dr,dc) in {-1,0,+1}^2, row-major, slot 0 = (-1,-1), slot 4 = centre.
- Wrap-around: row-1 at row 0 gives ROWS-1; row+1 at ROWS-1 gives 0. Columns wrap the same way. Implement wrap by compare/select, never by modulo or bit truncation.
- EVAL (1 cycle): n = popcount of the 8 neighbours (0..8, 4 bits).
  - next = centre ? SURVIVE_MASK[n] : BIRTH_MASK[n].
  - Result registered into o_wr_data.
- WRITE: o_wr_en, o_wr_addr, o_wr_data are held stable until i_wr_ready=1. The write completes on that cycle, and live accumulator += o_wr_data.
  - Then col++. On col wrap, col=0 and row++.
  - After the last cell (ROWS-1, COLS-1), go to DONE; otherwise go to FETCH.
- DONE (1 cycle): o_done=1, o_gen_count++ (wraps to 0), o_live_count <= accumulator, accumulator cleared, o_busy=0, then IDLE.
- Same-generation writes are never read back; the buffer swap is owned by the memory controller on o_done.
- Reset mid-generation: abandon immediately. No o_done. o_gen_count and o_live_count return to 0.
- i_rd_valid outside WAIT and i_wr_ready outside WRITE: ignored.
- Latency per cell, baseline, read latency L: 9*(1+L) + 1 + (write stall + 1) cycles.

Optional Feature:
CGOL_WINDOW_REUSE_EN
- Defined: when col advances within a row, the window shifts left by one column (slots 1,2,4,5,7,8 -> 0,1,3,4,6,7). Only the 3 new right-column cells are fetched, in slots 2,5,8 order. The first cell of each row still fetches all 9.
- Undefined: all 9 cells are fetched per cell.
- Written data and ordering are identical in both builds; only read count and timing differ.

Decomposition:
- Shared package cgol_pkg holds:
  - state enum: IDLE, FETCH, WAIT, EVAL, WRITE, DONE
  - window slot index constants
  - default B3/S23 mask constants
  - function wrap_inc/wrap_dec(value, limit)
- One sub-module, cgol_rule: combinational. Inputs: 9-bit window plus masks as parameters. Outputs: next-state bit and neighbour count.

Test Plan:
- 8x8, horizontal blinker at (3,2),(3,3),(3,4), L=1, i_wr_ready=1 -> written board has vertical blinker at (2,3),(3,3),(4,3); o_live_count=3, o_gen_count=1, o_done single pulse.
- 8x8 glider placed across corner (7,7)/(0,0), 4 generations -> glider shifted (+1,+1) with wrap, population 5 each generation.
- ROWS=5, COLS=7, single live cell at (0,0) -> all 35 writes 0, o_live_count=0; read addresses include 34, 6 and 28 (wrap checks).
- i_wr_ready held low 3 cycles on every write; i_start pulsed mid-run -> outputs stable during stalls, start ignored, exactly 64 writes.
- rst_n low during cell 20 -> all outputs 0 asynchronously, no o_done; next i_start restarts at address 0.
- With CGOL_WINDOW_REUSE_EN on 8x8: 240 read requests per generation, vs 576 without; written data identical.
